// File: rtl/logic_pipe_pkg.sv
// Shared constants for logic_pipe: opcode encodings and default geometry.
package logic_pipe_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_BUF_DEPTH = 2;

  localparam logic [2:0] OP_XOR  = 3'b000;
  localparam logic [2:0] OP_PASS = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_ORN  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_ANDN = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

endpackage

// File: rtl/logic_obuf.sv
// Circular output FIFO for logic_pipe; the head reads zero whenever the FIFO is empty.
module logic_obuf #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULLC);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    // Push and pop together leave the occupancy untouched.
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/logic_pipe.sv
// Bitwise logic unit with a 1-cycle result FIFO. Define LOGIC_PIPE_FLAGS_EN to add
// per-result all-zero / all-one flags (out_zero, out_ones).
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] valueC,
  input  logic [WIDTH-1:0] valueA,
  input  logic [2:0]       logic_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] value_out
`ifdef LOGIC_PIPE_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_ones
`endif
);
`ifdef LOGIC_PIPE_FLAGS_EN
  localparam int DW = WIDTH + 2;
`else
  localparam int DW = WIDTH;
`endif

  logic [WIDTH-1:0] res;
  logic [DW-1:0]    entry, head;
  logic             full, empty, push;
  logic             rdy_en_q, rdy_en_d;

  always_comb begin
    res = '0;
    unique case (logic_control)
      OP_XOR:  res = valueC ^ valueA;
      OP_PASS: res = valueC;
      OP_OR:   res = valueC | valueA;
      OP_ORN:  res = valueC | ~valueA;
      OP_AND:  res = valueC & valueA;
      OP_ANDN: res = valueC & ~valueA;
      OP_NOT:  res = ~valueA;
      OP_XNOR: res = ~(valueA ^ valueC);
      default: res = '0;
    endcase
  end

`ifdef LOGIC_PIPE_FLAGS_EN
  assign entry    = {&res, ~|res, res};
  assign out_ones = head[WIDTH+1];
  assign out_zero = head[WIDTH];
`else
  assign entry = res;
`endif

  // Holds in_ready low through reset and releases it on the first edge afterwards.
  always_comb rdy_en_d = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en_q <= 1'b0;
    else     rdy_en_q <= rdy_en_d;
  end

  assign in_ready  = rdy_en_q & ~full;
  assign push      = in_valid & in_ready;
  assign out_valid = ~empty;
  assign value_out = head[WIDTH-1:0];

  logic_obuf #(.DW(DW), .DEPTH(BUF_DEPTH)) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (entry),
    .pop       (out_ready),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_logic_pipe.sv
// Scoreboard bench: drivers push expected results on accept, monitors pop on output handshake.
module tb_logic_pipe;

  typedef struct {
    logic [31:0] d;
    logic        z;
    logic        o;
    int          ecyc;
    bit          lat;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // 32-bit / depth-2 instance
  logic        iv = 0, ir, ov, ordy = 0;
  logic [31:0] c32 = 0, a32 = 0, vo, exp32 = 0;
  logic [2:0]  op32 = 0;
  bit          lat32 = 0;
  // 8-bit / depth-4 instance
  logic        iv8 = 0, ir8, ov8, ordy8 = 0;
  logic [7:0]  c8 = 0, a8 = 0, vo8, exp8 = 0;
  logic [2:0]  op8 = 0;
`ifdef LOGIC_PIPE_FLAGS_EN
  logic oz, oo, oz8, oo8;
`endif

  ent_t q32[$];
  ent_t q8[$];
  int   n_acc32 = 0, n_pop32 = 0, n_acc8 = 0, n_pop8 = 0;

  logic_pipe #(.WIDTH(32), .BUF_DEPTH(2)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .valueC(c32), .valueA(a32),
    .logic_control(op32), .out_valid(ov), .out_ready(ordy), .value_out(vo)
`ifdef LOGIC_PIPE_FLAGS_EN
    , .out_zero(oz), .out_ones(oo)
`endif
  );

  logic_pipe #(.WIDTH(8), .BUF_DEPTH(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .valueC(c8), .valueA(a8),
    .logic_control(op8), .out_valid(ov8), .out_ready(ordy8), .value_out(vo8)
`ifdef LOGIC_PIPE_FLAGS_EN
    , .out_zero(oz8), .out_ones(oo8)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] c, input logic [63:0] a);
    case (op)
      3'd0:    return c ^ a;
      3'd1:    return c;
      3'd2:    return c | a;
      3'd3:    return c | ~a;
      3'd4:    return c & a;
      3'd5:    return c & ~a;
      3'd6:    return ~a;
      default: return ~(a ^ c);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv32(input logic [2:0] op, input logic [31:0] c, input logic [31:0] a,
                       input logic [31:0] e, input bit lat);
    iv = 1'b1; op32 = op; c32 = c; a32 = a; exp32 = e; lat32 = lat;
  endtask

  // Acceptors: record the expected result when a handshake is about to be taken.
  always @(negedge clk) if (!rst && iv && ir) begin
    q32.push_back('{exp32, exp32 == 32'h0, exp32 == 32'hFFFF_FFFF, cyc + 1, lat32});
    n_acc32++;
  end

  always @(negedge clk) if (!rst && iv8 && ir8) begin
    q8.push_back('{{24'h0, exp8}, exp8 == 8'h0, exp8 == 8'hFF, cyc + 1, 1'b0});
    n_acc8++;
  end

  // Monitors
  ent_t m32;
  always @(negedge clk) if (!rst) begin
    if (ov) begin
      if (ordy) begin
        if (q32.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL spurious32: got %h, expected no output", vo);
        end else begin
          m32 = q32.pop_front();
          n_pop32++;
          chk("data32", vo, m32.d);
          if (m32.lat) chk("latency32", cyc, m32.ecyc);
`ifdef LOGIC_PIPE_FLAGS_EN
          chk("zero32", oz, m32.z);
          chk("ones32", oo, m32.o);
`endif
        end
      end
    end else begin
      chk("idle32", vo, 0);
`ifdef LOGIC_PIPE_FLAGS_EN
      chk("idleflags32", {oz, oo}, 0);
`endif
    end
  end

  ent_t m8;
  logic       hold8_v = 0;
  logic [7:0] hold8_d = 0;
  always @(negedge clk) begin
    if (rst) hold8_v = 0;
    else begin
      if (hold8_v && ov8) chk("stable8", vo8, hold8_d);
      hold8_v = ov8 && !ordy8;
      hold8_d = vo8;
      if (ov8) begin
        if (ordy8) begin
          if (q8.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL spurious8: got %h, expected no output", vo8);
          end else begin
            m8 = q8.pop_front();
            n_pop8++;
            chk("data8", vo8, m8.d);
`ifdef LOGIC_PIPE_FLAGS_EN
            chk("flags8", {oz8, oo8}, {m8.z, m8.o});
`endif
          end
        end
      end else chk("idle8", vo8, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] s1_exp [8];
  int p0, a0;

  initial begin
    s1_exp = '{32'h0FF00FF0, 32'hF0F0F0F0, 32'hFFF0FFF0, 32'hF0FFF0FF,
               32'hF000F000, 32'h00F000F0, 32'h00FF00FF, 32'hF00FF00F};
    // Reset state
    #1;
    chk("rst_valid", ov, 0);
    chk("rst_value", vo, 0);
    chk("rst_ready", ir, 0);
    #11 rst = 1'b0;
    #1 chk("ready_before_edge", ir, 0);
    step();
    chk("ready_after_edge", ir, 1);
    chk("ready8_after_edge", ir8, 1);

    // Scenario 1: every opcode, one cycle latency
    ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drv32(3'(i), 32'hF0F0F0F0, 32'hFF00FF00, s1_exp[i], 1'b1);
      step();
    end
    iv = 1'b0;
    repeat (3) step();

    // Scenario 2: back-pressure, two accepted, head stable
    ordy = 1'b0;
    a0 = n_acc32;
    drv32(3'b001, 32'h0000_00A1, 32'h0, 32'h0000_00A1, 1'b0); step();
    drv32(3'b001, 32'h0000_00A2, 32'h0, 32'h0000_00A2, 1'b0); step();
    chk("full_ready", ir, 0);
    drv32(3'b001, 32'h0000_00A3, 32'h0, 32'h0000_00A3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("held_head", vo, 32'h0000_00A1);
      chk("held_ready", ir, 0);
    end
    iv = 1'b0;
    chk("accepted2", n_acc32 - a0, 2);
    ordy = 1'b1;
    for (int k = 0; k < 10 && q32.size() != 0; k++) step();
    chk("drain2_empty", q32.size(), 0);
    step();

    // Scenario 3: count held at 1, one result per cycle
    ordy = 1'b0;
    drv32(3'b001, 32'h100, 32'h0, 32'h100, 1'b0); step();
    ordy = 1'b1;
    p0 = n_pop32;
    for (int k = 1; k <= 10; k++) begin
      drv32(3'b000, 32'h100 + k, 32'h0, 32'h100 + k, 1'b0);
      chk("s3_valid", ov, 1);
      chk("s3_ready", ir, 1);
      step();
    end
    iv = 1'b0;
    chk("s3_pops", n_pop32 - p0, 10);
    for (int k = 0; k < 10 && q32.size() != 0; k++) step();
    chk("drain3_empty", q32.size(), 0);

    // Scenario 4: reset with two results buffered
    ordy = 1'b0;
    drv32(3'b100, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'hDEAD_0000, 1'b0); step();
    drv32(3'b110, 32'h0, 32'h1234_5678, 32'hEDCB_A987, 1'b0); step();
    iv = 1'b0;
    chk("s4_full", ir, 0);
    #2 rst = 1'b1;
    #1;
    chk("s4_rst_valid", ov, 0);
    chk("s4_rst_value", vo, 0);
    chk("s4_rst_ready", ir, 0);
    q32.delete();
    q8.delete();
    step();
    #2 rst = 1'b0;
    ordy = 1'b1;
    chk("s4_ready_pre", ir, 0);
    step();
    chk("s4_ready_post", ir, 1);
    for (int k = 0; k < 3; k++) begin
      chk("s4_no_stale", ov, 0);
      step();
    end

`ifdef LOGIC_PIPE_FLAGS_EN
    // Scenario 5: flags
    drv32(3'b100, 32'h0000FFFF, 32'hFFFF0000, 32'h0, 1'b1); step();
    drv32(3'b110, 32'h1357_9BDF, 32'h0, 32'hFFFF_FFFF, 1'b1); step();
    iv = 1'b0;
    repeat (3) step();
`endif

    // Scenario 6: random traffic on the 8-bit, depth-4 instance
    for (int k = 0; k < 400; k++) begin
      iv8   = 1'($urandom_range(0, 1));
      ordy8 = 1'($urandom_range(0, 3) != 0);
      op8   = 3'($urandom_range(0, 7));
      c8    = 8'($urandom);
      a8    = 8'($urandom);
      exp8  = 8'(ref_op(op8, {56'h0, c8}, {56'h0, a8}));
      step();
    end
    iv8 = 1'b0;
    ordy8 = 1'b1;
    for (int k = 0; k < 20 && q8.size() != 0; k++) step();
    chk("drain8_empty", q8.size(), 0);
    chk("count8", n_pop8, n_acc8);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
